// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
// Optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W    = 10;
  localparam int unsigned IMEM_DEPTH     = 1024;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler with optional running XOR of payload bytes.
// XOR accumulator exists only when IMEM_LOADER_CHECKSUM_EN is defined.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] wdata_o,
  output logic        word_full_o
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  xor_o
`endif
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d  = xor_q;
`endif
    if (clear_i) begin
      idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d = '0;
`endif
    end else if (accept_i) begin
      data_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d = xor_q ^ byte_i;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q  <= '0;
`endif
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q  <= xor_d;
`endif
    end
  end

  assign wdata_o     = data_q;
  assign word_full_o = accept_i && (idx_q == 2'(BYTES_PER_WORD - 1));
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign xor_o       = xor_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as sequential 32-bit words, holding the core meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_TAIL = ST_CHECK;
`else
  localparam state_e ST_TAIL = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              err_q, err_d;
  logic              in_ready_q, we_q, busy_q, done_q;
  logic              pk_clear, pk_accept, word_full, last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        ck_xor;
`endif

  byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear),
    .accept_i    (pk_accept),
    .byte_i      (in_data),
    .wdata_o     (wdata),
    .word_full_o (word_full)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .xor_o       (ck_xor)
`endif
  );

  // Compared in ADDR_W+1 bits so a DEPTH-word load ends at DEPTH-1 before the counter wraps.
  assign last_word = ({1'b0, waddr_q} == (len_q - (ADDR_W + 1)'(1)));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    waddr_d   = waddr_q;
    err_d     = err_q;
    pk_clear  = 1'b0;
    pk_accept = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = len;
          waddr_d  = '0;
          err_d    = 1'b0;
          pk_clear = 1'b1;
          if (len > (ADDR_W + 1)'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (len == '0) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        pk_accept = in_valid && in_ready_q;
        if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        waddr_d = waddr_q + ADDR_W'(1);
        state_d = last_word ? ST_TAIL : ST_RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (in_valid && in_ready_q) begin
          if (in_data != ck_xor) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      waddr_q    <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      waddr_q    <= waddr_d;
      err_q      <= err_d;
      in_ready_q <= (state_d == ST_RECV) || (state_d == ST_CHECK);
      we_q       <= (state_d == ST_WRITE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus random loads against a word-level model.
// Checksum scenarios are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned AW  = IMEM_ADDR_W;
  localparam int unsigned DEP = IMEM_DEPTH;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [AW:0]   len;
  logic [7:0]    in_data;
  logic          in_ready, we, busy, cpu_hold, done, err;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  imem_loader #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc = 0, done_cnt = 0, viol = 0, done_cyc = 0;
  logic [31:0] mem [0:DEP-1];
  logic [AW-1:0] wa_q [$];
  logic [31:0]   wd_q [$];
  int unsigned   wc_q [$];
  logic [7:0]    pay [0:4*DEP-1];

  // Instruction memory stand-in plus a log of every write and done pulse.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we) begin
      mem[waddr] <= wdata;
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      wc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (we && in_ready) viol <= viol + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input int unsigned i);
    return {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
  endfunction

  function automatic logic [7:0] model_xor(input int unsigned n);
    logic [7:0] x = 8'h00;
    for (int unsigned i = 0; i < 4 * n; i++) x = x ^ pay[i];
    return x;
  endfunction

  task automatic fill_pay(input int unsigned n);
    for (int unsigned i = 0; i < 4 * n; i++) pay[i] = 8'($urandom);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic start_load(input int unsigned n);
    start = 1'b1;
    len   = (AW + 1)'(n);
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
    repeat (gap) tick();
  endtask

  task automatic check_outputs_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_we"},       32'(we),       32'd0);
    chk({tag, "_waddr"},    32'(waddr),    32'd0);
    chk({tag, "_wdata"},    wdata,         32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic wait_done(input string tag, input int unsigned d0);
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    chk({tag, "_done_count"}, done_cnt, d0 + 1);
    chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic check_writes(input string tag, input int unsigned n);
    int unsigned m;
    chk({tag, "_write_count"}, wa_q.size(), n);
    m = (wa_q.size() < n) ? wa_q.size() : n;
    for (int unsigned i = 0; i < m; i++) begin
      chk({tag, "_waddr"}, 32'(wa_q[i]), i);
      chk({tag, "_wdata"}, wd_q[i], model_word(i));
      chk({tag, "_mem"},   mem[i],  model_word(i));
    end
  endtask

  task automatic run_load(input string tag, input int unsigned n, input int unsigned gap,
                          input bit bad_ck);
    int unsigned d0;
    clear_log();
    d0 = done_cnt;
    start_load(n);
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_hold_after_start"}, 32'(cpu_hold), 32'd1);
    if (n > 0) chk({tag, "_ready_after_start"}, 32'(in_ready), 32'd1);
    for (int unsigned i = 0; i < 4 * n; i++) send_byte(pay[i], gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(model_xor(n) ^ (bad_ck ? 8'h01 : 8'h00), gap);
    chk({tag, "_err"}, 32'(err), 32'(bad_ck));
`else
    chk({tag, "_err"}, 32'(err), 32'd0);
`endif
    wait_done(tag, d0);
    check_writes(tag, n);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (wc_q.size() > 0) chk({tag, "_done_after_last_we"}, done_cyc, wc_q[$] + 1);
`endif
  endtask

  initial begin
    int unsigned d0, lat, n, gap;
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    check_outputs_reset("reset");
    reset = 1'b0;
    tick();

    // Two-word back-to-back load from the test plan.
    pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h50; pay[3] = 8'h00;
    pay[4] = 8'h93; pay[5] = 8'h00; pay[6] = 8'h10; pay[7] = 8'h00;
    run_load("basic", 2, 0, 1'b0);
    chk("basic_mem0", mem[0], 32'h00500013);
    chk("basic_mem1", mem[1], 32'h00100093);
    if (wc_q.size() == 2) chk("basic_throughput", wc_q[1] - wc_q[0], 32'd5);

    // One byte every third cycle.
    pay[0] = 8'hEF; pay[1] = 8'hBE; pay[2] = 8'hAD; pay[3] = 8'hDE;
    run_load("gapped", 1, 2, 1'b0);
    chk("gapped_mem0", mem[0], 32'hDEADBEEF);
    chk("ready_during_write", viol, 32'd0);

    // Oversized load is rejected without writes.
    clear_log();
    start_load(DEP + 1);
    lat = 0;
    while (!done && lat < 10) begin tick(); lat++; end
    chk("oversize_done_latency_ok", 32'(lat <= 2), 32'd1);
    chk("oversize_err", 32'(err), 32'd1);
    tick();
    chk("oversize_busy_after", 32'(busy), 32'd0);
    chk("oversize_err_sticky", 32'(err), 32'd1);
    chk("oversize_no_write", wa_q.size(), 32'd0);

    run_load("len0", 0, 0, 1'b0);

    // Reset in the middle of the second word.
    fill_pay(3);
    clear_log();
    start_load(3);
    for (int unsigned i = 0; i < 6; i++) send_byte(pay[i], 0);
    reset = 1'b1;
    tick();
    check_outputs_reset("midreset");
    reset = 1'b0;
    chk("midreset_write_count", wa_q.size(), 32'd1);
    if (wa_q.size() > 0) begin
      chk("midreset_waddr0", 32'(wa_q[0]), 32'd0);
      chk("midreset_wdata0", wd_q[0], model_word(0));
    end
    tick();
    fill_pay(1);
    run_load("after_reset", 1, 1, 1'b0);

    // start pulse while busy must not disturb the load.
    fill_pay(2);
    clear_log();
    d0 = done_cnt;
    start_load(2);
    for (int unsigned i = 0; i < 3; i++) send_byte(pay[i], 0);
    start = 1'b1; len = (AW + 1)'(7);
    tick();
    start = 1'b0; len = '0;
    chk("restart_busy", 32'(busy), 32'd1);
    for (int unsigned i = 3; i < 8; i++) send_byte(pay[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(model_xor(2), 0);
`endif
    wait_done("restart", d0);
    check_writes("restart", 2);

    for (int r = 0; r < 10; r++) begin
      n   = $urandom_range(1, 6);
      gap = $urandom_range(0, 3);
      fill_pay(n);
      run_load("rand", n, gap, 1'b0);
    end

    // Full-depth load: last write at DEPTH-1, no wrapped write afterwards.
    fill_pay(DEP);
    run_load("full", DEP, 0, 1'b0);
    repeat (5) tick();
    chk("full_no_wrap", wa_q.size(), DEP);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h04; pay[3] = 8'h08;
    run_load("ck_good", 1, 0, 1'b0);
    chk("ck_good_mem0", mem[0], 32'h08040201);
    run_load("ck_bad", 1, 0, 1'b1);
    chk("ck_bad_mem0", mem[0], 32'h08040201);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
